// File: rtl/uop_sequencer.sv
// Micro-op sequencer: queues decoded bundles and issues one uop per cycle.
// Optional same-cycle issue of lone uop_0 bundles: define UOP_SEQ_BYPASS_EN.
module uop_sequencer #(
  parameter int DEPTH = 4,
  parameter int UOP_W = 20
) (
  input  logic                     clk,
  input  logic                     a_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [UOP_W-1:0]         in_uop_0,
  input  logic [UOP_W-1:0]         in_uop_1,
  input  logic [UOP_W-1:0]         in_uop_2,
  input  logic [1:0]               in_uop_count,
  input  logic                     hold,
  input  logic                     flush,
  output logic                     exec_valid,
  input  logic                     exec_ready,
  output logic [UOP_W-1:0]         exec_uop,
  output logic                     exec_last,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [UOP_W-1:0] uop0_q [DEPTH];
  logic [UOP_W-1:0] uop1_q [DEPTH];
  logic [UOP_W-1:0] uop2_q [DEPTH];
  logic [1:0]       cnt_q  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [1:0]    idx_q, idx_d;

  logic [AW-1:0]    rd_next;
  logic [UOP_W-1:0] head_uop;
  logic             byp, push, offer, xfer, pop;

  function automatic logic [1:0] clamp(input logic [1:0] c);
    return (c == 2'd3) ? 2'd2 : c;
  endfunction

  always_comb begin
    in_ready = (occ_q != OW'(DEPTH)) & ~flush;
    byp = 1'b0;
`ifdef UOP_SEQ_BYPASS_EN
    byp = (occ_q == '0) & in_valid & (in_uop_count == 2'd0)
        & ~hold & ~flush & exec_ready;
`endif
    push  = in_valid & in_ready & ~byp;
    offer = (occ_q != '0) & ~hold & ~flush;

    head_uop = '0;
    unique case (1'b1)
      (idx_q == 2'd0): head_uop = uop0_q[rd_ptr_q];
      (idx_q == 2'd1): head_uop = uop1_q[rd_ptr_q];
      default:         head_uop = uop2_q[rd_ptr_q];
    endcase

    exec_valid = offer;
    exec_uop   = offer ? head_uop : '0;
    exec_last  = offer & (idx_q == 2'd0);
    if (byp) begin
      exec_valid = 1'b1;
      exec_uop   = in_uop_0;
      exec_last  = 1'b1;
    end

    xfer    = offer & exec_ready;
    pop     = xfer & (idx_q == 2'd0);
    rd_next = rd_ptr_q + AW'(1);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    idx_d    = idx_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      idx_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_next;
      occ_d = occ_q + OW'(push) - OW'(pop);
      // A pop that empties the queue hands the head to a same-cycle push
      if (pop) begin
        if (occ_q > OW'(1))
          idx_d = clamp(cnt_q[rd_next]);
        else if (push)
          idx_d = clamp(in_uop_count);
        else
          idx_d = '0;
      end else if (xfer) begin
        idx_d = idx_q - 2'd1;
      end else if (push && occ_q == '0) begin
        idx_d = clamp(in_uop_count);
      end
    end

    occupancy = occ_q;
    busy      = (occ_q != '0);
  end

  always_ff @(posedge clk) begin
    if (a_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      idx_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      idx_q    <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!a_rst && push) begin
      uop0_q[wr_ptr_q] <= in_uop_0;
      uop1_q[wr_ptr_q] <= in_uop_1;
      uop2_q[wr_ptr_q] <= in_uop_2;
      cnt_q[wr_ptr_q]  <= in_uop_count;
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Scoreboard bench for uop_sequencer: directed plan cases then random traffic.
// Reference keeps a flat queue of expected issued uops in architectural order.
module tb_uop_sequencer;

  localparam int DEPTH = 4;
  localparam int UOP_W = 20;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             a_rst;
  logic             in_valid;
  logic             in_ready;
  logic [UOP_W-1:0] in_uop_0, in_uop_1, in_uop_2;
  logic [1:0]       in_uop_count;
  logic             hold, flush;
  logic             exec_valid, exec_ready;
  logic [UOP_W-1:0] exec_uop;
  logic             exec_last;
  logic [OW-1:0]    occupancy;
  logic             busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [UOP_W-1:0] uop;
    bit               last;
  } item_t;

  item_t exp_q[$];

  always #5 clk = ~clk;

  uop_sequencer #(.DEPTH(DEPTH), .UOP_W(UOP_W)) dut (
    .clk(clk), .a_rst(a_rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_uop_0(in_uop_0), .in_uop_1(in_uop_1), .in_uop_2(in_uop_2),
    .in_uop_count(in_uop_count),
    .hold(hold), .flush(flush),
    .exec_valid(exec_valid), .exec_ready(exec_ready),
    .exec_uop(exec_uop), .exec_last(exec_last),
    .occupancy(occupancy), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sample just before each rising edge, compare, then advance model
  initial begin
    forever begin
      int m_occ;
      int c;
      bit byp, e_inr, e_ev;
      @(negedge clk);
      #4;
      if (a_rst) begin
        exp_q.delete();
      end else begin
        m_occ = 0;
        foreach (exp_q[i]) if (exp_q[i].last) m_occ++;
        byp = 1'b0;
`ifdef UOP_SEQ_BYPASS_EN
        byp = (m_occ == 0) && in_valid && in_uop_count == 2'd0
           && !hold && !flush && exec_ready;
`endif
        e_inr = (m_occ != DEPTH) && !flush;
        e_ev  = byp || (m_occ != 0 && !hold && !flush);
        check("in_ready", 32'(in_ready), 32'(e_inr));
        check("exec_valid", 32'(exec_valid), 32'(e_ev));
        check("occupancy", 32'(occupancy), 32'(m_occ));
        check("busy", 32'(busy), 32'(m_occ != 0));
        if (e_ev && byp) begin
          check("byp_uop", 32'(exec_uop), 32'(in_uop_0));
          check("byp_last", 32'(exec_last), 32'd1);
        end else if (e_ev) begin
          check("exec_uop", 32'(exec_uop), 32'(exp_q[0].uop));
          check("exec_last", 32'(exec_last), 32'(exp_q[0].last));
        end else begin
          check("idle_uop", 32'(exec_uop), 32'd0);
          check("idle_last", 32'(exec_last), 32'd0);
        end
        if (flush) begin
          exp_q.delete();
        end else begin
          if (e_ev && exec_ready && !byp) void'(exp_q.pop_front());
          if (in_valid && e_inr && !byp) begin
            c = (in_uop_count == 2'd3) ? 2 : int'(in_uop_count);
            if (c == 2) exp_q.push_back('{in_uop_2, 1'b0});
            if (c >= 1) exp_q.push_back('{in_uop_1, 1'b0});
            exp_q.push_back('{in_uop_0, 1'b1});
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic bundle(input logic [1:0] cnt, input logic [UOP_W-1:0] u2,
                        input logic [UOP_W-1:0] u1,
                        input logic [UOP_W-1:0] u0);
    in_valid     = 1'b1;
    in_uop_count = cnt;
    in_uop_2     = u2;
    in_uop_1     = u1;
    in_uop_0     = u0;
  endtask

  initial begin
    a_rst = 1'b1;
    in_valid = 1'b0;
    in_uop_0 = '0;
    in_uop_1 = '0;
    in_uop_2 = '0;
    in_uop_count = 2'd0;
    hold = 1'b0;
    flush = 1'b0;
    exec_ready = 1'b0;
    step();
    step();
    a_rst = 1'b0;
    step();

    exec_ready = 1'b1;
    bundle(2'd2, 20'h00001, 20'h00002, 20'h00003);
    step();
    in_valid = 1'b0;
    repeat (5) step();

    exec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bundle(2'd0, '0, '0, 20'(16 + i));
      step();
    end
    bundle(2'd0, '0, '0, 20'h00099);
    step();
    in_valid = 1'b0;
    exec_ready = 1'b1;
    repeat (8) step();

    bundle(2'd3, 20'h00021, 20'h00022, 20'h00023);
    step();
    in_valid = 1'b0;
    repeat (5) step();

    bundle(2'd2, 20'h00031, 20'h00032, 20'h00033);
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    bundle(2'd1, '0, 20'h00041, 20'h00042);
    step();
    in_valid = 1'b0;
    repeat (5) step();

    exec_ready = 1'b0;
    bundle(2'd1, '0, 20'h00051, 20'h00052);
    step();
    in_valid = 1'b0;
    step();
    hold = 1'b1;
    exec_ready = 1'b1;
    bundle(2'd0, '0, '0, 20'h00053);
    step();
    in_valid = 1'b0;
    step();
    step();
    hold = 1'b0;
    repeat (6) step();

    exec_ready = 1'b0;
    bundle(2'd2, 20'h00061, 20'h00062, 20'h00063);
    step();
    in_valid = 1'b0;
    exec_ready = 1'b1;
    step();
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    repeat (4) step();

    for (int n = 0; n < 600; n++) begin
      in_valid     = ($urandom_range(0, 99) < 60);
      in_uop_count = 2'($urandom_range(0, 3));
      in_uop_0     = 20'($urandom);
      in_uop_1     = 20'($urandom);
      in_uop_2     = 20'($urandom);
      hold         = ($urandom_range(0, 99) < 10);
      flush        = ($urandom_range(0, 99) < 3);
      exec_ready   = ($urandom_range(0, 99) < 70);
      a_rst        = ($urandom_range(0, 199) == 0);
      step();
    end

    a_rst = 1'b0;
    in_valid = 1'b0;
    hold = 1'b0;
    flush = 1'b0;
    exec_ready = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uop_sequencer.md
Name: uop_sequencer

Overview:
- Sits between the instruction decoder and the execute stage.
- Buffers decoded micro-op bundles of up to 3 uops each and issues them one uop per cycle.
- Issue order within a bundle is uop_2 → uop_1 → uop_0. uop_0 is always the architectural last step and carries the flag write.
- Decouples decoder feed_req/feed_ack pacing from execute back-pressure, and supports hold and pipeline flush.

Parameters:
- DEPTH, 4, number of bundle entries in the queue; power of two, ≥ 2.
- UOP_W, 20, width of one micro-op word.

Ports:
- clk  input  1  core clock.
- a_rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  decoder presents a valid bundle.
- in_ready  output  1  sequencer can accept a bundle this cycle.
- in_uop_0  input  UOP_W  last-step uop.
- in_uop_1  input  UOP_W  middle uop.
- in_uop_2  input  UOP_W  first uop.
- in_uop_count  input  2  0 = uop_0 only; 1 = uop_1, uop_0; 2 = uop_2, uop_1, uop_0; 3 is treated as 2.
- hold  input  1  stall; freezes issue.
- flush  input  1  discard all queued and partially issued bundles.
- exec_valid  output  1  exec_uop is valid.
- exec_ready  input  1  execute stage accepts exec_uop.
- exec_uop  output  UOP_W  uop being issued.
- exec_last  output  1  exec_uop is the bundle's uop_0.
- occupancy  output  $clog2(DEPTH)+1  number of bundles held, including a partially issued one.
- busy  output  1  occupancy != 0.

Behaviour:
- Storage: circular queue of DEPTH entries, each holding {uop_2, uop_1, uop_0, count}. Write pointer, read pointer, and occupancy counter. Pointers wrap modulo DEPTH.
- Issue index register idx (2 bits) points at the uop of the head entry currently offered.
- Reset (a_rst = 1 at a clk edge): pointers = 0, occupancy = 0, idx = 0. Outputs after reset: in_ready = 1, exec_valid = 0, exec_last = 0, exec_uop = 0, busy = 0.
- Accept: push when in_valid & in_ready.
  - in_ready = (occupancy != DEPTH) & ~flush.
  - Full is evaluated on the registered occupancy. A pop in the same cycle does not free a slot for a push in that cycle.
- Push into an empty queue: idx loads the clamped count on the same edge. The first uop appears on exec_valid on the next cycle (latency 1, no bypass).
- Offer: exec_valid = (occupancy != 0) & ~hold & ~flush.
  - exec_uop = head.uop[idx] when exec_valid is 1, otherwise 0.
  - exec_last = exec_valid & (idx == 0).
- Transfer: when exec_valid & exec_ready.
  - idx > 0: idx decrements.
  - idx == 0: head pops (read pointer +1, occupancy −1). idx loads the clamped count of the next entry; if the queue becomes empty, idx loads the count of the entry being pushed in the same cycle, if any.
- Simultaneous push and pop: occupancy is unchanged; both pointers advance.
- hold = 1: no transfer, no idx change. Pushes still occur while not full. exec_uop/exec_valid are forced to 0.
- flush = 1 (highest priority after reset): on the edge, pointers, occupancy and idx are cleared. No push or pop occurs that cycle. in_ready = 0 and exec_valid = 0 combinationally during the flush cycle.
- Reset or flush mid-bundle: the remaining uops of the partial bundle are discarded and never issued.
- exec_valid, once asserted, keeps exec_uop stable until transfer, hold, or flush.

Optional Feature:
- Macro: UOP_SEQ_BYPASS_EN.
- Defined:
  - When occupancy == 0, in_valid = 1, in_uop_count == 0, ~hold, ~flush and exec_ready = 1, in_uop_0 drives exec_uop combinationally.
  - exec_valid = 1 and exec_last = 1 in the same cycle.
  - The bundle is consumed without being written to the queue; occupancy stays 0.
  - If exec_ready = 0, the bundle is enqueued normally.
- Undefined: no combinational in→exec path; minimum latency is 1 cycle for all bundles.

Test Plan:
- Reset, then push bundle {count=2, uops 0x00003/0x00002/0x00001}, exec_ready = 1 → cycles 1–3 issue 0x00001, 0x00002, 0x00003; exec_last only with 0x00003; occupancy returns to 0.
- Push 4 single-uop bundles with exec_ready = 0 (DEPTH = 4) → occupancy = 4, in_ready = 0; a 5th in_valid is not accepted. Raise exec_ready → issue order is preserved, and in_ready = 1 one cycle after the first pop.
- Bundle count=3 (illegal encoding) → issued as 3 uops, identical to count=2.
- Mid-bundle: after uop_2 is issued, assert flush for 1 cycle → remaining uops are never issued; occupancy = 0; a new bundle pushed after the flush issues normally.
- Assert hold for 3 cycles while a count=1 bundle is at the head → exec_valid = 0 throughout, idx is unchanged, and a pushed bundle increments occupancy. On hold release, uop_1 is issued first.
- With UOP_SEQ_BYPASS_EN: empty queue, in_valid with count=0 and exec_ready = 1 → exec_valid = 1 and exec_last = 1 in the same cycle, exec_uop = in_uop_0, occupancy stays 0.
